// File: rtl/sram_8k_pkg.sv
//==============================================================================
// Module      : sram_8k_pkg
// Description : Shared widths, rw encodings and word typedefs for sram_8k.
//               Optional feature macro: SRAM_8K_PARITY_EN (adds even_parity).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package sram_8k_pkg;

    localparam int   ADDR_W_DEF = 13;
    localparam int   DATA_W_DEF = 8;
    localparam int   DEPTH      = 2 ** ADDR_W_DEF;

    localparam logic RW_READ    = 1'b1;
    localparam logic RW_WRITE   = 1'b0;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [DATA_W_DEF-1:0] data_t;

`ifdef SRAM_8K_PARITY_EN
    // Returns the bit that makes the word plus parity contain an even number of ones.
    function automatic logic even_parity(input data_t d);
        return ^d;
    endfunction
`endif

endpackage

`default_nettype wire

// File: rtl/sram_8k_if.sv
//==============================================================================
// Module      : sram_8k_if
// Description : Access bus for sram_8k (address, rw, enable, data in/out).
//               Optional feature macro: SRAM_8K_PARITY_EN (parity_err, inject_err).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface sram_8k_if #(
    parameter int ADDR_W = sram_8k_pkg::ADDR_W_DEF,
    parameter int DATA_W = sram_8k_pkg::DATA_W_DEF
);

    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic              en;

`ifdef SRAM_8K_PARITY_EN
    logic              parity_err;
    logic              inject_err;

    modport master (
        output data_in, addr, rw, en, inject_err,
        input  data_out, parity_err
    );

    modport slave (
        input  data_in, addr, rw, en, inject_err,
        output data_out, parity_err
    );
`else
    modport master (
        output data_in, addr, rw, en,
        input  data_out
    );

    modport slave (
        input  data_in, addr, rw, en,
        output data_out
    );
`endif

endinterface

`default_nettype wire

// File: rtl/sram_8k.sv
//==============================================================================
// Module      : sram_8k
// Description : Single-port synchronous RAM, 2**ADDR_W x DATA_W, registered read.
//               Optional feature macro: SRAM_8K_PARITY_EN (stored even parity).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sram_8k
    import sram_8k_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [DATA_W-1:0] RST_DOUT = '0
) (
    input  wire        clk,
    input  wire        rst,
    sram_8k_if.slave   bus
);

    localparam int c_depth  = 2 ** ADDR_W;
`ifdef SRAM_8K_PARITY_EN
    localparam int c_word_w = DATA_W + 1;
`else
    localparam int c_word_w = DATA_W;
`endif

    logic [c_word_w-1:0] r_mem [c_depth];
    logic [DATA_W-1:0]   r_dout;
    logic [c_word_w-1:0] w_wr_word;
    logic [c_word_w-1:0] w_rd_word;
    logic                w_wr;
    logic                w_rd;

    assign w_wr      = bus.en && (bus.rw == RW_WRITE);
    assign w_rd      = bus.en && (bus.rw == RW_READ);
    assign w_rd_word = r_mem[bus.addr];

`ifdef SRAM_8K_PARITY_EN
    logic r_parity_err;

    assign w_wr_word = {even_parity(data_t'(bus.data_in)) ^ bus.inject_err, bus.data_in};
`else
    assign w_wr_word = bus.data_in;
`endif

    // Array has no reset so it maps onto block RAM; rst only gates the write.
    always_ff @(posedge clk) begin
        if (!rst && w_wr) begin
            r_mem[bus.addr] <= w_wr_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout <= RST_DOUT;
        end else if (w_rd) begin
            r_dout <= w_rd_word[DATA_W-1:0];
        end
    end

`ifdef SRAM_8K_PARITY_EN
    // Flag is only meaningful on the cycle after a read; cleared otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else if (w_rd) begin
            r_parity_err <= w_rd_word[DATA_W] != even_parity(data_t'(w_rd_word[DATA_W-1:0]));
        end else begin
            r_parity_err <= 1'b0;
        end
    end

    assign bus.parity_err = r_parity_err;
`endif

    assign bus.data_out = r_dout;

endmodule

`default_nettype wire

// File: tb/tb_sram_8k.sv
//==============================================================================
// Module      : tb_sram_8k
// Description : Self-checking bench for sram_8k against an array reference model.
//               Optional feature macro: SRAM_8K_PARITY_EN (parity checks enabled).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sram_8k;

    logic clk;
    logic rst;

    int n_cmp;
    int n_err;

    // Reference model: plain word array, expected registered output, bad-parity marks.
    logic [7:0] model_mem [8192];
    bit         model_bad [8192];
    logic [7:0] exp_dout;
    logic       exp_perr;

    sram_8k_if #(.ADDR_W(13), .DATA_W(8)) bus ();

    sram_8k #(.ADDR_W(13), .DATA_W(8), .RST_DOUT(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, clock, update model, compare registered outputs.
    task automatic do_cycle(input string tag, input logic e, input logic r,
                            input int unsigned a, input logic [7:0] d,
                            input logic inj = 1'b0);
        bus.en      = e;
        bus.rw      = r;
        bus.addr    = 13'(a);
        bus.data_in = d;
`ifdef SRAM_8K_PARITY_EN
        bus.inject_err = inj;
`endif
        @(posedge clk);
        #1;
        exp_perr = 1'b0;
        if (e && !r) begin
            model_mem[a] = d;
            model_bad[a] = inj;
        end
        if (e && r) begin
            exp_dout = model_mem[a];
            exp_perr = model_bad[a];
        end
        check(tag, bus.data_out, exp_dout);
`ifdef SRAM_8K_PARITY_EN
        check({tag, "_perr"}, 8'(bus.parity_err), 8'(exp_perr));
`endif
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        exp_dout    = 8'h00;
        exp_perr    = 1'b0;
        rst         = 1'b1;
        bus.en      = 1'b0;
        bus.rw      = 1'b1;
        bus.addr    = '0;
        bus.data_in = '0;
`ifdef SRAM_8K_PARITY_EN
        bus.inject_err = 1'b0;
`endif

        // Reset state
        #3;
        check("reset_dout", bus.data_out, 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Disabled writes must not touch a preloaded word
        do_cycle("preload0", 1'b1, 1'b0, 0, 8'h11);
        do_cycle("idle_wr1", 1'b0, 1'b0, 0, 8'hFF);
        do_cycle("idle_wr2", 1'b0, 1'b0, 0, 8'hFF);
        do_cycle("rd_pre0",  1'b1, 1'b1, 0, 8'h00);
        check("rd_pre0_const", bus.data_out, 8'h11);

        // Write/read, read-after-write, no write-through
        do_cycle("wr0_ff", 1'b1, 1'b0, 0, 8'hFF);
        do_cycle("rd0_ff", 1'b1, 1'b1, 0, 8'h00);
        do_cycle("wr1_aa", 1'b1, 1'b0, 1, 8'hAA);
        do_cycle("rd0",    1'b1, 1'b1, 0, 8'h00);
        do_cycle("rd1",    1'b1, 1'b1, 1, 8'h00);
        check("rd1_const", bus.data_out, 8'hAA);

        // Enable gating holds output
        do_cycle("hold_en0", 1'b0, 1'b1, 0, 8'h00);
        check("hold_const", bus.data_out, 8'hAA);
        do_cycle("reen_rd0", 1'b1, 1'b1, 0, 8'h00);

        // Top address and persistence through an asynchronous reset pulse
        do_cycle("wr_top", 1'b1, 1'b0, 8191, 8'h5C);
        do_cycle("wr0_c5", 1'b1, 1'b0, 0,    8'hC5);
        #3 rst = 1'b1;
        #1 check("rst_async", bus.data_out, 8'h00);
        exp_dout = 8'h00;
        #1 rst = 1'b0;
        do_cycle("rd_top", 1'b1, 1'b1, 8191, 8'h00);
        check("rd_top_const", bus.data_out, 8'h5C);
        do_cycle("rd0_c5", 1'b1, 1'b1, 0, 8'h00);

        // Write sampled while rst is high is dropped
        bus.en      = 1'b1;
        bus.rw      = 1'b0;
        bus.addr    = 13'd0;
        bus.data_in = 8'h99;
        rst         = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        exp_dout = 8'h00;
        check("rst_wr_dout", bus.data_out, 8'h00);
        do_cycle("rd0_after_rst_wr", 1'b1, 1'b1, 0, 8'h00);

`ifdef SRAM_8K_PARITY_EN
        do_cycle("par_wr_inj", 1'b1, 1'b0, 5, 8'h3C, 1'b1);
        do_cycle("par_rd_inj", 1'b1, 1'b1, 5, 8'h00);
        do_cycle("par_idle",   1'b0, 1'b1, 5, 8'h00);
        do_cycle("par_wr_ok",  1'b1, 1'b0, 5, 8'h3C, 1'b0);
        do_cycle("par_rd_ok",  1'b1, 1'b1, 5, 8'h00);
`endif

        // Randomized traffic over a pool of low and high addresses
        for (int i = 0; i < 32; i++) begin
            do_cycle("rnd_pre", 1'b1, 1'b0, (i < 16) ? i : 8160 + i, 8'($urandom));
        end
        for (int i = 0; i < 400; i++) begin
            int unsigned idx;
            idx = $urandom_range(0, 31);
            do_cycle("rnd", ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                     (idx < 16) ? idx : 8160 + idx, 8'($urandom)
`ifdef SRAM_8K_PARITY_EN
                     , 1'($urandom_range(0, 3) == 0)
`endif
                     );
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
